// File: rtl/alu_flow_pkg.sv
// Shared opcodes, status-register bit positions and FSM encoding for the program-flow unit.
package alu_flow_pkg;

    localparam int WIDTH = 20;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_TRAP = 4'd1;
    localparam logic [3:0] OP_JMP  = 4'd2;
    localparam logic [3:0] OP_JZ   = 4'd3;
    localparam logic [3:0] OP_JS   = 4'd4;
    localparam logic [3:0] OP_JZS  = 4'd5;
    localparam logic [3:0] OP_LDSR = 4'd6;
    localparam logic [3:0] OP_XSR  = 4'd7;

    localparam int SR_Z = 0;
    localparam int SR_S = 1;
    localparam int SR_C = 2;
    localparam int SR_T = 3;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_TRAP   = 2'd1,
        ST_RETURN = 2'd2
    } flow_state_t;

    // Opcodes 8..15 are illegal and take the trap path alongside TRAP itself.
    function automatic logic is_trap_op(input logic [3:0] op);
        return (op == OP_TRAP) || op[3];
    endfunction

endpackage

// File: rtl/alu_flow_sr.sv
// 4-bit status register {T,C,S,Z}; updates one edge after its controls are sampled.
// No backpressure: every control is applied on the cycle it is presented.
module alu_flow_sr
    import alu_flow_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flag_we,
    input  logic       zero_in,
    input  logic       sign_in,
    input  logic       carry_in,
    input  logic       ld_vld,
    input  logic       xor_vld,
    input  logic [3:0] operand,
    input  logic       t_set,
    input  logic       t_clr,
    output logic [3:0] sr
);

    logic [3:0] sr_d;
    logic [3:0] sr_q;

    // An explicit SR op overrides a coincident ALU flag write on all four bits.
    always_comb begin
        sr_d = sr_q;
        if (flag_we) begin
            sr_d[SR_Z] = zero_in;
            sr_d[SR_S] = sign_in;
            sr_d[SR_C] = carry_in;
        end
        if (ld_vld) begin
            sr_d = operand;
        end else if (xor_vld) begin
            sr_d = sr_q ^ operand;
        end
        if (t_set) begin
            sr_d[SR_T] = 1'b1;
        end else if (t_clr) begin
            sr_d[SR_T] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= 4'b0000;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign sr = sr_q;

endmodule

// File: rtl/alu_flow_ctrl.sv
// Program counter, jump evaluation and trap FSM; pc/sr/taken update one edge after acceptance.
// ready_out depends on state only: high in RUN, low through TRAP and RETURN.
module alu_flow_ctrl #(
    parameter int                 WIDTH       = alu_flow_pkg::WIDTH,
    parameter logic [WIDTH-1:0]   RESET_PC    = 20'h00000,
    parameter logic [WIDTH-1:0]   TRAP_VECTOR = 20'hFFF00
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    output logic             ready_out,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] target,
    input  logic             flag_we,
    input  logic             zero_in,
    input  logic             sign_in,
    input  logic             carry_in,
    input  logic             trap_ack,
    output logic [WIDTH-1:0] pc,
    output logic [3:0]       sr,
    output logic             taken,
    output logic             trap_active,
    output logic [WIDTH-1:0] epc
);

    import alu_flow_pkg::*;

    localparam logic [WIDTH-1:0] PC_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    flow_state_t      state_d, state_q;
    logic [WIDTH-1:0] pc_d, pc_q;
    logic [WIDTH-1:0] epc_d, epc_q;
    logic             taken_d, taken_q;

    logic             accept;
    logic             jump_hit;
    logic             sr_ld, sr_xor, t_set, t_clr;
    logic [3:0]       sr_cur;

    assign ready_out = (state_q == ST_RUN);
    assign accept    = valid_in && ready_out;

    // Conditions look only at the registered SR, never at this cycle's flag write.
    always_comb begin
        jump_hit = 1'b0;
        case (op)
            OP_JMP:  jump_hit = 1'b1;
            OP_JZ:   jump_hit = sr_cur[SR_Z];
            OP_JS:   jump_hit = sr_cur[SR_S];
            OP_JZS:  jump_hit = sr_cur[SR_Z] | sr_cur[SR_S];
            default: jump_hit = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        epc_d   = epc_q;
        taken_d = 1'b0;
        sr_ld   = 1'b0;
        sr_xor  = 1'b0;
        t_set   = 1'b0;
        t_clr   = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (accept) begin
                    if (is_trap_op(op)) begin
                        epc_d   = pc_q;
                        pc_d    = TRAP_VECTOR;
                        t_set   = 1'b1;
                        state_d = ST_TRAP;
                    end else if (jump_hit) begin
                        pc_d    = target;
                        taken_d = 1'b1;
                    end else begin
                        pc_d   = pc_q + PC_ONE;
                        sr_ld  = (op == OP_LDSR);
                        sr_xor = (op == OP_XSR);
                    end
                end
            end
            ST_TRAP: begin
                if (trap_ack) begin
                    state_d = ST_RETURN;
                end
            end
            ST_RETURN: begin
                pc_d    = epc_q + PC_ONE;
                t_clr   = 1'b1;
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            epc_q   <= '0;
            taken_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            taken_q <= taken_d;
        end
    end

    alu_flow_sr u_sr (
        .clk      (clk),
        .rst_n    (rst_n),
        .flag_we  (flag_we),
        .zero_in  (zero_in),
        .sign_in  (sign_in),
        .carry_in (carry_in),
        .ld_vld   (sr_ld),
        .xor_vld  (sr_xor),
        .operand  (target[3:0]),
        .t_set    (t_set),
        .t_clr    (t_clr),
        .sr       (sr_cur)
    );

    assign pc          = pc_q;
    assign epc         = epc_q;
    assign sr          = sr_cur;
    assign taken       = taken_q;
    assign trap_active = (state_q != ST_RUN);

endmodule

// File: tb/tb_alu_flow_ctrl.sv
// Directed bench for alu_flow_ctrl: flags, jumps, SR priority, PC wrap, trap round trip, reset mid-trap.
module tb_alu_flow_ctrl;

    logic        clk;
    logic        rst_n;
    logic        valid_in;
    logic        ready_out;
    logic [3:0]  op;
    logic [19:0] target;
    logic        flag_we;
    logic        zero_in;
    logic        sign_in;
    logic        carry_in;
    logic        trap_ack;
    logic [19:0] pc;
    logic [3:0]  sr;
    logic        taken;
    logic        trap_active;
    logic [19:0] epc;

    int n_cmp;
    int n_err;

    alu_flow_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .valid_in    (valid_in),
        .ready_out   (ready_out),
        .op          (op),
        .target      (target),
        .flag_we     (flag_we),
        .zero_in     (zero_in),
        .sign_in     (sign_in),
        .carry_in    (carry_in),
        .trap_ack    (trap_ack),
        .pc          (pc),
        .sr          (sr),
        .taken       (taken),
        .trap_active (trap_active),
        .epc         (epc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        valid_in = 1'b0;
        op       = 4'd0;
        target   = 20'h0;
        flag_we  = 1'b0;
        zero_in  = 1'b0;
        sign_in  = 1'b0;
        carry_in = 1'b0;
        trap_ack = 1'b0;

        // Reset
        tick();
        tick();
        chk("rst_pc", 32'(pc), 32'h0);
        chk("rst_sr", 32'(sr), 32'h0);
        chk("rst_ready", 32'(ready_out), 32'h1);
        chk("rst_trap_active", 32'(trap_active), 32'h0);
        chk("rst_taken", 32'(taken), 32'h0);
        chk("rst_epc", 32'(epc), 32'h0);
        rst_n = 1'b1;
        tick();

        // Flag write sets Z
        flag_we = 1'b1; zero_in = 1'b1;
        tick();
        flag_we = 1'b0; zero_in = 1'b0;
        chk("flag_sr", 32'(sr), 32'h1);
        chk("flag_pc_hold", 32'(pc), 32'h0);

        // JZ taken
        valid_in = 1'b1; op = 4'd3; target = 20'h00ABC;
        tick();
        chk("jz_pc", 32'(pc), 32'h00ABC);
        chk("jz_taken", 32'(taken), 32'h1);

        // JS not taken; taken drops back after one cycle
        op = 4'd4; target = 20'h00123;
        tick();
        chk("js_pc", 32'(pc), 32'h00ABD);
        chk("js_taken", 32'(taken), 32'h0);

        // LDSR beats a coincident flag write
        op = 4'd6; target = 20'h00004; flag_we = 1'b1; sign_in = 1'b1;
        tick();
        flag_we = 1'b0; sign_in = 1'b0;
        chk("ldsr_sr", 32'(sr), 32'h4);
        chk("ldsr_pc", 32'(pc), 32'h00ABE);

        // XSR
        op = 4'd7; target = 20'h00005;
        tick();
        chk("xsr_sr", 32'(sr), 32'h1);
        chk("xsr_pc", 32'(pc), 32'h00ABF);

        // JMP to top of range, then NOP wraps
        op = 4'd2; target = 20'hFFFFF;
        tick();
        chk("jmp_max_pc", 32'(pc), 32'hFFFFF);
        chk("jmp_max_taken", 32'(taken), 32'h1);
        op = 4'd0;
        tick();
        chk("wrap_pc", 32'(pc), 32'h0);
        chk("wrap_taken", 32'(taken), 32'h0);

        // Trap round trip from pc=0x10
        op = 4'd2; target = 20'h00010;
        tick();
        chk("pre_trap_pc", 32'(pc), 32'h00010);
        op = 4'd1; target = 20'h0;
        tick();
        chk("trap_epc", 32'(pc == 20'hFFF00 ? epc : 20'hDEAD0), 32'h00010);
        chk("trap_pc", 32'(pc), 32'hFFF00);
        chk("trap_sr", 32'(sr), 32'h9);
        chk("trap_ready", 32'(ready_out), 32'h0);
        chk("trap_active", 32'(trap_active), 32'h1);

        // JMP ignored in TRAP; flags still update
        op = 4'd2; target = 20'h00055; flag_we = 1'b1; carry_in = 1'b1;
        tick();
        valid_in = 1'b0; flag_we = 1'b0; carry_in = 1'b0;
        chk("trap_ign_pc", 32'(pc), 32'hFFF00);
        chk("trap_ign_taken", 32'(taken), 32'h0);
        chk("trap_flag_sr", 32'(sr), 32'hC);
        chk("trap_ign_ready", 32'(ready_out), 32'h0);

        // trap_ack -> RETURN -> RUN
        trap_ack = 1'b1;
        tick();
        trap_ack = 1'b0;
        chk("ret_ready", 32'(ready_out), 32'h0);
        chk("ret_active", 32'(trap_active), 32'h1);
        chk("ret_pc_hold", 32'(pc), 32'hFFF00);
        tick();
        chk("run_pc", 32'(pc), 32'h00011);
        chk("run_sr", 32'(sr), 32'h4);
        chk("run_ready", 32'(ready_out), 32'h1);
        chk("run_active", 32'(trap_active), 32'h0);

        // Illegal opcode traps like TRAP
        valid_in = 1'b1; op = 4'hC;
        tick();
        valid_in = 1'b0; op = 4'd0;
        chk("ill_epc", 32'(epc), 32'h00011);
        chk("ill_pc", 32'(pc), 32'hFFF00);
        chk("ill_sr", 32'(sr), 32'hC);
        chk("ill_active", 32'(trap_active), 32'h1);

        // Asynchronous reset mid-trap
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_pc", 32'(pc), 32'h0);
        chk("arst_sr", 32'(sr), 32'h0);
        chk("arst_active", 32'(trap_active), 32'h0);
        chk("arst_ready", 32'(ready_out), 32'h1);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_pc", 32'(pc), 32'h0);
        valid_in = 1'b1; op = 4'd0;
        tick();
        valid_in = 1'b0;
        chk("post_rst_nop_pc", 32'(pc), 32'h1);
        chk("post_rst_active", 32'(trap_active), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_flow_ctrl.md
# alu_flow_ctrl

Program-flow and status-register unit that sits downstream of the ALU. It consumes the ALU zero, sign and carry flags and holds them in a 4-bit status register (SR). It executes the program-flow class of operations (trap, no-op, unconditional and conditional jumps, load-SR, XOR-SR) and owns the 20-bit program counter. A small state machine handles trap entry and trap return with a handshake to the trap handler.

## Interface
Parameters:
- WIDTH, 20, word width of PC, jump target and SR load data
- RESET_PC, 20'h00000, PC value after reset
- TRAP_VECTOR, 20'hFFF00, PC value while in trap

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- valid_in  in  1  flow instruction presented this cycle
- ready_out  out  1  unit accepts an instruction this cycle; transfer when valid_in && ready_out
- op  in  4  flow opcode
- target  in  WIDTH  jump target / SR operand (low 4 bits used for SR ops)
- flag_we  in  1  ALU result valid; latch flags into SR
- zero_in, sign_in, carry_in  in  1 each  ALU flags
- trap_ack  in  1  handler done, return from trap
- pc  out  WIDTH  current program counter
- sr  out  4  status register {T,C,S,Z} (bit3..bit0)
- taken  out  1  registered; 1 for the cycle after an accepted jump that was taken
- trap_active  out  1  unit in trap
- epc  out  WIDTH  PC of the trapping instruction

Decided: one clock; reset is asynchronous and active-low.

## Operation
- Opcodes:
  - 0 NOP
  - 1 TRAP
  - 2 JMP
  - 3 JZ: taken if Z
  - 4 JS: taken if S
  - 5 JZS: taken if Z|S
  - 6 LDSR: SR <= target[3:0]
  - 7 XSR: SR <= SR ^ target[3:0]
  - 8–15 are illegal and behave as TRAP with SR.T set.
- Non-jump or not-taken accepted instruction: pc <= pc+1, wrapping modulo 2^WIDTH (20'hFFFFF -> 0).
- Taken jump: pc <= target.
- Conditions evaluate the SR value registered before the current edge. A same-cycle flag_we does not affect the decision.
- flag_we (independent of valid_in) loads Z,S,C from the inputs; T is unchanged.
- If flag_we coincides with an accepted LDSR/XSR, the SR op wins for all 4 bits.
- The FSM has three states:
  - RUN: ready_out=1. An accepted TRAP or illegal opcode does epc <= pc, pc <= TRAP_VECTOR, SR.T <= 1, and moves to TRAP.
  - TRAP: ready_out=0, trap_active=1, pc held. flag_we still updates Z,S,C. When trap_ack=1, go to RETURN.
  - RETURN: ready_out=0, trap_active=1. Does pc <= epc+1 (wrapping), SR.T <= 0, then moves to RUN.
- While not in RUN, valid_in is ignored and no state changes except flags.
- trap_ack outside TRAP is ignored.

## Timing
- Reset values: pc=RESET_PC, sr=0, epc=0, taken=0, trap_active=0, ready_out=1, state RUN.
- Reset asserted mid-trap aborts it immediately; there is no pending return.
- Latency:
  - pc, sr and taken update one edge after acceptance; taken is high for exactly one cycle.
  - TRAP entry: trap_active high the cycle after acceptance.
  - Return: ready_out high again 2 cycles after the trap_ack edge (TRAP->RETURN->RUN).
- ready_out is a function of the state only; it has no combinational path from valid_in.
- Back-to-back instructions are accepted every cycle in RUN.

## Structure
- Shared package alu_flow_pkg holds:
  - opcode constants: OP_NOP..OP_XSR
  - SR bit indices: SR_Z=0, SR_S=1, SR_C=2, SR_T=3
  - FSM state encoding: ST_RUN, ST_TRAP, ST_RETURN
  - WIDTH default 20, so it matches the ALU word.
- One natural sub-module, alu_flow_sr: the 4-bit status register with flag_we/LDSR/XSR priority and T set/clear. The top keeps the PC, the FSM and jump evaluation.

## Test plan
- Reset: hold rst_n=0 for 2 cycles, release -> pc=0, sr=0, ready_out=1, trap_active=0.
- Flags and JZ:
  - flag_we with zero_in=1 -> sr=4'b0001.
  - Next cycle accept JZ target=20'h00ABC -> pc=20'h00ABC, taken=1 for one cycle.
  - JS at that point -> not taken, pc=20'h00ABD.
- Priority: in the same cycle, flag_we with sign_in=1 and LDSR target[3:0]=4'b0100 -> sr=4'b0100. Then XSR 4'b0101 -> sr=4'b0001.
- Wrap: JMP to 20'hFFFFF, then NOP -> pc=20'h00000.
- Trap round trip:
  - At pc=20'h00010, accept TRAP -> epc=20'h00010, pc=20'hFFF00, sr[3]=1, ready_out=0.
  - valid_in JMP while in TRAP -> ignored.
  - trap_ack -> two cycles later pc=20'h00011, sr[3]=0, ready_out=1.
- Illegal opcode and reset mid-trap:
  - op=4'hC -> trap entry identical to TRAP.
  - rst_n low while in TRAP -> pc=RESET_PC, sr=0, trap_active=0 asynchronously.
